// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-memory port between load line-fills and write-through stores.
// It grants one transaction at a time, breaks ties round-robin, and aborts beats that wait too long.
module mem_port_arbiter #(
    parameter int LINE_W   = 256,
    parameter int MAX_WAIT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_req,
    input  logic [31:0]       ld_addr,
    output logic              ld_done,
    output logic [LINE_W-1:0] ld_line,
    input  logic              st_req,
    input  logic [31:0]       st_addr,
    input  logic [31:0]       st_data,
    input  logic              st_alloc,
    output logic              st_done,
    output logic [LINE_W-1:0] st_line,
    output logic              err,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LD_RD = 2'd1;
    localparam logic [1:0] S_ST_WR = 2'd2;
    localparam logic [1:0] S_ST_RD = 2'd3;

    localparam logic LG_LD = 1'b0;
    localparam logic LG_ST = 1'b1;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    logic [1:0] state;
    logic       last_grant;
    logic [7:0] wait_cnt;
    logic       alloc_q;

    logic ld_eligible;
    logic st_eligible;
    logic grant_ld;
    logic grant_st;
    logic timeout;

    // A requester still showing its done pulse must not be re-granted off the same request.
    assign ld_eligible = ld_req && !ld_done;
    assign st_eligible = st_req && !st_done;
    assign grant_ld    = ld_eligible && (!st_eligible || last_grant == LG_ST);
    assign grant_st    = st_eligible && !grant_ld;
    assign timeout     = !mem_ready && (wait_cnt == WAIT_LIMIT);
    assign busy        = (state != S_IDLE);

    // Byte-offset bits never reach the memory port.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ld_addr[4:0], st_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= LG_ST;
            wait_cnt   <= '0;
            alloc_q    <= 1'b0;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            ld_done    <= 1'b0;
            st_done    <= 1'b0;
            err        <= 1'b0;
            ld_line    <= '0;
            st_line    <= '0;
        end else begin
            // NOTE: the done/err pulses default low every cycle; only a finishing branch raises them.
            ld_done <= 1'b0;
            st_done <= 1'b0;
            err     <= 1'b0;
            case (state)
                S_IDLE: begin
                    wait_cnt <= '0;
                    if (grant_ld) begin
                        state      <= S_LD_RD;
                        last_grant <= LG_LD;
                        mem_valid  <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= {ld_addr[31:5], 5'b0};
                    end else if (grant_st) begin
                        state      <= S_ST_WR;
                        last_grant <= LG_ST;
                        alloc_q    <= st_alloc;
                        mem_valid  <= 1'b1;
                        mem_we     <= 1'b1;
                        mem_addr   <= {st_addr[31:2], 2'b0};
                        mem_wdata  <= st_data;
                    end
                end
                S_LD_RD: begin
                    if (mem_ready || timeout) begin
                        ld_line   <= mem_ready ? mem_rdata : '0;
                        ld_done   <= 1'b1;
                        err       <= !mem_ready;
                        state     <= S_IDLE;
                        mem_valid <= 1'b0;
                        mem_we    <= 1'b0;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_ST_WR: begin
                    if (mem_ready && alloc_q) begin
                        // mem_valid stays high straight into the allocate read.
                        state    <= S_ST_RD;
                        mem_we   <= 1'b0;
                        mem_addr <= {st_addr[31:5], 5'b0};
                        wait_cnt <= '0;
                    end else if (mem_ready || timeout) begin
                        if (!mem_ready) begin
                            st_line <= '0;
                        end
                        st_done   <= 1'b1;
                        err       <= !mem_ready;
                        state     <= S_IDLE;
                        mem_valid <= 1'b0;
                        mem_we    <= 1'b0;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_ST_RD: begin
                    if (mem_ready || timeout) begin
                        st_line   <= mem_ready ? mem_rdata : '0;
                        st_done   <= 1'b1;
                        err       <= !mem_ready;
                        state     <= S_IDLE;
                        mem_valid <= 1'b0;
                        mem_we    <= 1'b0;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of the memory port and the timeout rule.
module tb_mem_port_arbiter;

    localparam int W        = 256;
    localparam int MAX_WAIT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         ld_req;
    logic [31:0]  ld_addr;
    logic         ld_done;
    logic [W-1:0] ld_line;
    logic         st_req;
    logic [31:0]  st_addr;
    logic [31:0]  st_data;
    logic         st_alloc;
    logic         st_done;
    logic [W-1:0] st_line;
    logic         err;
    logic         mem_valid;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ready;
    logic [W-1:0] mem_rdata;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_ld_line;
    logic [W-1:0] exp_st_line;

    mem_port_arbiter #(.LINE_W(W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_done   (ld_done),
        .ld_line   (ld_line),
        .st_req    (st_req),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_alloc  (st_alloc),
        .st_done   (st_done),
        .st_line   (st_line),
        .err       (err),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_line();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Checks one memory beat presented at the current cycle. The beat sees mem_ready low for
    // 'delay' cycles; if that exceeds MAX_WAIT the arbiter gives up after MAX_WAIT+1 cycles.
    // Returns positioned on the cycle after completion or abort.
    task automatic serve_beat(input string tag, input logic exp_we, input logic [31:0] exp_addr,
                              input logic [31:0] exp_wdata, input int delay, input logic [W-1:0] data);
        int n_low;
        n_low = (delay > MAX_WAIT) ? MAX_WAIT + 1 : delay;
        for (int i = 0; i <= n_low; i++) begin
            if (i == n_low && delay > MAX_WAIT) break;
            check({tag, "_valid"}, W'(mem_valid), W'(1'b1));
            check({tag, "_we"}, W'(mem_we), W'(exp_we));
            check({tag, "_addr"}, W'(mem_addr), W'(exp_addr));
            if (exp_we) check({tag, "_wdata"}, W'(mem_wdata), W'(exp_wdata));
            if (i < n_low) begin
                mem_ready = 1'b0;
                mem_rdata = rand_line();
            end else begin
                mem_ready = 1'b1;
                mem_rdata = data;
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        mem_rdata = rand_line();
    endtask

    task automatic expect_ld_done(input logic to, input logic [W-1:0] data);
        exp_ld_line = to ? '0 : data;
        check("ld_done", W'(ld_done), W'(1'b1));
        check("ld_st_done_low", W'(st_done), W'(1'b0));
        check("ld_err", W'(err), W'(to));
        check("ld_line", ld_line, exp_ld_line);
        check("ld_st_line_hold", st_line, exp_st_line);
        check("ld_done_valid_low", W'(mem_valid), W'(1'b0));
        check("ld_done_busy_low", W'(busy), W'(1'b0));
    endtask

    task automatic expect_st_done(input logic to, input logic alloc, input logic [W-1:0] data);
        if (to) exp_st_line = '0;
        else if (alloc) exp_st_line = data;
        check("st_done", W'(st_done), W'(1'b1));
        check("st_ld_done_low", W'(ld_done), W'(1'b0));
        check("st_err", W'(err), W'(to));
        check("st_line", st_line, exp_st_line);
        check("st_ld_line_hold", ld_line, exp_ld_line);
        check("st_done_valid_low", W'(mem_valid), W'(1'b0));
    endtask

    task automatic run_load(input logic [31:0] a, input int delay);
        logic [W-1:0] data;
        data    = rand_line();
        ld_req  = 1'b1;
        ld_addr = a;
        @(negedge clk);
        serve_beat("ld_rd", 1'b0, {a[31:5], 5'b0}, 32'h0, delay, data);
        expect_ld_done(delay > MAX_WAIT, data);
        ld_req = 1'b0;
        @(negedge clk);
        check("ld_after_idle", W'({busy, mem_valid, ld_done}), W'(3'b000));
    endtask

    task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic alloc,
                             input int delay_w, input int delay_r);
        logic [W-1:0] data;
        logic         to;
        data     = rand_line();
        st_req   = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_alloc = alloc;
        @(negedge clk);
        serve_beat("st_wr", 1'b1, {a[31:2], 2'b0}, d, delay_w, rand_line());
        to = (delay_w > MAX_WAIT);
        if (!to && alloc) begin
            serve_beat("st_rd", 1'b0, {a[31:5], 5'b0}, 32'h0, delay_r, data);
            to = (delay_r > MAX_WAIT);
        end
        expect_st_done(to, alloc, data);
        st_req = 1'b0;
        @(negedge clk);
        check("st_after_idle", W'({busy, mem_valid, st_done}), W'(3'b000));
    endtask

    initial begin
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        rst       = 1'b1;
        ld_req    = 1'b0;
        ld_addr   = '0;
        st_req    = 1'b0;
        st_addr   = '0;
        st_data   = '0;
        st_alloc  = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        exp_ld_line = '0;
        exp_st_line = '0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_mem_valid", W'(mem_valid), W'(1'b0));
        check("rst_mem_we", W'(mem_we), W'(1'b0));
        check("rst_mem_addr", W'(mem_addr), W'(32'h0));
        check("rst_mem_wdata", W'(mem_wdata), W'(32'h0));
        check("rst_ld_done", W'(ld_done), W'(1'b0));
        check("rst_st_done", W'(st_done), W'(1'b0));
        check("rst_err", W'(err), W'(1'b0));
        check("rst_busy", W'(busy), W'(1'b0));
        check("rst_ld_line", ld_line, '0);
        check("rst_st_line", st_line, '0);
        rst = 1'b0;
        @(negedge clk);

        // Load fill, store with allocate
        run_load(32'h0000_1234, 0);
        run_store(32'h0000_0040, 32'hDEAD_BEEF, 1'b1, 3, 3);

        // Round-robin tie: both requests held high across four grants
        ld_req   = 1'b1;
        ld_addr  = 32'h0000_5A7C;
        st_req   = 1'b1;
        st_addr  = 32'h0000_9006;
        st_data  = 32'h1234_5678;
        st_alloc = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            d0 = rand_line();
            serve_beat("rr_ld", 1'b0, 32'h0000_5A60, 32'h0, 0, d0);
            expect_ld_done(1'b0, d0);
            if (k == 1) ld_req = 1'b0;
            @(negedge clk);
            serve_beat("rr_st", 1'b1, 32'h0000_9004, 32'h1234_5678, 0, rand_line());
            expect_st_done(1'b0, 1'b0, d0);
            if (k == 1) st_req = 1'b0;
            @(negedge clk);
        end
        check("rr_end_idle", W'({busy, mem_valid}), W'(2'b00));

        // Timeout on a load, then a normal load
        run_load(32'h8000_0100, MAX_WAIT + 3);
        run_load(32'h8000_0120, 1);

        // Reset during the write beat of an allocating store
        st_req   = 1'b1;
        st_addr  = 32'h0000_0F0C;
        st_data  = 32'hCAFE_F00D;
        st_alloc = 1'b1;
        @(negedge clk);
        check("mid_wr_valid", W'({mem_valid, mem_we}), W'(2'b11));
        rst     = 1'b1;
        ld_req  = 1'b1;
        ld_addr = 32'h0000_3333;
        @(negedge clk);
        exp_ld_line = '0;
        exp_st_line = '0;
        check("mid_rst_valid", W'(mem_valid), W'(1'b0));
        check("mid_rst_busy", W'(busy), W'(1'b0));
        check("mid_rst_done", W'({st_done, ld_done, err}), W'(3'b000));
        rst = 1'b0;
        @(negedge clk);
        d0 = rand_line();
        serve_beat("post_rst_ld", 1'b0, 32'h0000_3320, 32'h0, 0, d0);
        expect_ld_done(1'b0, d0);
        ld_req = 1'b0;
        @(negedge clk);
        d1 = rand_line();
        serve_beat("post_rst_wr", 1'b1, 32'h0000_0F0C, 32'hCAFE_F00D, 0, rand_line());
        serve_beat("post_rst_rd", 1'b0, 32'h0000_0F00, 32'h0, 0, d1);
        expect_st_done(1'b0, 1'b1, d1);
        st_req = 1'b0;
        @(negedge clk);

        // Randomized single-requester transactions, including timeouts
        for (int n = 0; n < 30; n++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            if (kind == 0) run_load($urandom, int'($urandom_range(0, MAX_WAIT + 2)));
            else run_store($urandom, $urandom, kind == 2,
                           int'($urandom_range(0, MAX_WAIT + 2)), int'($urandom_range(0, MAX_WAIT + 2)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the single data-memory port between the cache controller's two miss paths: load line-fills and write-through stores, which may allocate. It grants one transaction at a time, using round-robin on ties, and drives a valid/ready memory handshake. It returns the 256-bit line to the requester with a one-cycle done pulse and aborts any transaction that memory fails to complete within a bounded wait. It sits between the cache controller and data memory, and it replaces the cache's free-running `new_mem` broadcast.

## Interface
- `LINE_W`, 256: memory line width in bits; lines are aligned on `addr[31:5]`.
- `MAX_WAIT`, 64: number of consecutive cycles that `mem_valid` may stay high without `mem_ready` before the arbiter aborts; range 2..255.
- `clk` in 1: the only clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ld_req` in 1: load-miss fill request; held high until `ld_done`.
- `ld_addr` in 32: load byte address; stable while `ld_req` is high.
- `ld_done` out 1: one-cycle pulse; `ld_line` and `err` are valid in that cycle.
- `ld_line` out LINE_W: returned line; holds its value until the next load completion.
- `st_req` in 1: store request; held high until `st_done`.
- `st_addr` in 32: store word address; bits [1:0] are ignored.
- `st_data` in 32: store word.
- `st_alloc` in 1: when 1, the write is followed by a line read (store-miss allocate).
- `st_done` out 1: one-cycle pulse that ends the store.
- `st_line` out LINE_W: allocated line; valid with `st_done` only when `st_alloc` was 1.
- `err` out 1: qualifies the done pulse in the same cycle; 1 means the transaction timed out.
- `mem_valid` out 1: memory request valid.
- `mem_we` out 1: 1 for a write, 0 for a line read.
- `mem_addr` out 32: `{addr[31:5],5'b0}` for reads; `{st_addr[31:2],2'b0}` for writes.
- `mem_wdata` out 32: write data.
- `mem_ready` in 1: memory accepts or completes; a beat completes on a cycle where `mem_valid` and `mem_ready` are both high.
- `mem_rdata` in LINE_W: read line; valid in the completing cycle of a read.
- `busy` out 1: high in every state except IDLE.

## Operation
- **States:** IDLE, LD_RD, ST_WR, ST_RD.
- **IDLE:**
  - Samples the requests; a requester whose done pulse is high this cycle is masked.
  - Only `ld_req` high → LD_RD.
  - Only `st_req` high → ST_WR.
  - Both high → the requester not granted last wins.
  - `last_grant` updates on each grant; its reset value is ST, so load wins the first tie.
- **LD_RD:**
  - Drives `mem_valid=1`, `mem_we=0`, and the line address from `ld_addr`.
  - On completion: `ld_line<=mem_rdata`, `ld_done<=1`, `err<=0`, → IDLE.
- **ST_WR:**
  - Drives `mem_valid=1`, `mem_we=1`, the word address and `st_data`.
  - On completion with `st_alloc=1` → ST_RD.
  - On completion with `st_alloc=0`: `st_done<=1`, → IDLE.
- **ST_RD:**
  - Line read at `{st_addr[31:5],5'b0}`.
  - On completion: `st_line<=mem_rdata`, `st_done<=1`, → IDLE.
- **Wait counter (8 bits):**
  - Clears on every state entry and on every completion.
  - Increments in each cycle of LD_RD, ST_WR or ST_RD in which `mem_ready=0`.
  - On the cycle it would reach `MAX_WAIT`, the arbiter aborts: the current requester's done pulse fires with `err<=1`, its line output is loaded with 0, and the state returns to IDLE.
  - An abort in ST_WR does not proceed to ST_RD.
- `ld_done` and `st_done` are never high in the same cycle.
- Request inputs are not re-sampled during a transaction; dropping `*_req` mid-transaction does not cancel it.

## Timing
- **Reset values:** state IDLE, `last_grant`=ST, counter 0, and all outputs 0 (`mem_valid`, `mem_we`, `mem_addr`, `mem_wdata`, `ld_done`, `st_done`, `err`, `busy`, `ld_line`, `st_line`).
- **Reset mid-transaction:** `mem_valid` drops at the next edge and no done pulse is issued.
- `mem_*` outputs are registered. Request seen in IDLE at cycle N → `mem_valid` high at N+1.
- **Load:** with `mem_ready` high at N+1, `ld_done` fires at N+2; minimum latency is 2 cycles.
- **Store without allocate:** minimum latency is 2 cycles.
- **Store with allocate:** write completes at N+1, read `mem_valid` at N+2, `st_done` at N+3.
- `mem_valid` stays high continuously from ST_WR into ST_RD; `mem_we` falls at the transition.
- `mem_addr`, `mem_we` and `mem_wdata` are stable while `mem_valid` is high and `mem_ready` is low.
- The done cycle is an IDLE cycle; the other requester can be granted in it, giving `mem_valid` again at done+1.
- **Timeout:** with `mem_ready` stuck at 0, the done pulse with `err=1` appears exactly `MAX_WAIT`+1 cycles after `mem_valid` first rises.

## Test plan
- **Load fill:** `ld_req` with `ld_addr`=0x0000_1234; `mem_ready` held high → `mem_addr`=0x0000_1220, `mem_we`=0; `ld_done` at 2 cycles; `ld_line` equals `mem_rdata`; `err`=0.
- **Store with allocate:** `st_addr`=0x40, `st_data`=0xDEADBEEF, `st_alloc`=1; `mem_ready` low for 3 cycles per beat → write beat (`mem_we`=1, `mem_addr`=0x40), then read beat (`mem_addr`=0x40); `st_done` with `st_line` equal to the read data.
- **Round-robin tie:** `ld_req` and `st_req` rise together after reset, both re-request after done → order is load, store, load, store; no idle gap beyond the done cycle.
- **Timeout:** `MAX_WAIT`=4, `mem_ready` stuck at 0 → `ld_done` with `err`=1 and `ld_line`=0, 5 cycles after `mem_valid` rose; next request is served normally.
- **Reset mid-transaction:** `rst` asserted during ST_WR → `mem_valid`=0 and `busy`=0 on the next edge; no `st_done`; after release a pending `ld_req` wins (`last_grant`=ST).
